// File: rtl/csr_unit_pkg.sv
// csr_unit_pkg: shared CSR types, addresses, bit positions and helpers for csr_unit.
// The counter addresses are only decoded when ZICNTR_EN is defined.
package csr_unit_pkg;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_mode_t;

   typedef struct packed {
      logic       valid;
      logic       use_imm;
      csr_mode_t  csr_mode;
      logic [11:0] csr_target;
   } csr_req_t;

   localparam logic [11:0] CSR_ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_ADDR_MIE       = 12'h304;
   localparam logic [11:0] CSR_ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_ADDR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_ADDR_MIP       = 12'h344;
   localparam logic [11:0] CSR_ADDR_MHARTID   = 12'hF14;
   localparam logic [11:0] CSR_ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_ADDR_INSTRETH  = 12'hC82;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIX_MSI      = 3;
   localparam int MIX_MTI      = 7;
   localparam int MIX_MEI      = 11;

   typedef enum logic [31:0] {
      CAUSE_ILLEGAL_INSTR = 32'h0000_0002,
      CAUSE_BREAKPOINT    = 32'h0000_0003,
      CAUSE_ECALL_M       = 32'h0000_000B,
      CAUSE_M_SW_IRQ      = 32'h8000_0003,
      CAUSE_M_TIMER_IRQ   = 32'h8000_0007,
      CAUSE_M_EXT_IRQ     = 32'h8000_000B
   } cause_t;

   // Place the three interrupt bits {MEI, MTI, MSI} at their mie/mip positions
   function automatic logic [31:0] mix_expand(input logic [2:0] bits3);
      logic [31:0] v;
      v          = '0;
      v[MIX_MSI] = bits3[0];
      v[MIX_MTI] = bits3[1];
      v[MIX_MEI] = bits3[2];
      return v;
   endfunction

   // mstatus as read: only MIE/MPIE are stored, MPP reads as machine mode
   function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
      logic [31:0] v;
      v               = '0;
      v[MSTATUS_MIE]  = mie;
      v[MSTATUS_MPIE] = mpie;
      v[12:11]        = 2'b11;
      return v;
   endfunction

   // Trap target: direct base, or base + 4*cause for interrupts in vectored mode
   function automatic logic [31:0] trap_vector(input logic [31:0] mtvec, input logic [31:0] cause);
      logic [31:0] base;
      base = {mtvec[31:2], 2'b00};
      if (mtvec[0] && cause[31]) begin
         return base + {25'b0, cause[4:0], 2'b00};
      end
      return base;
   endfunction

endpackage

// File: rtl/csr_unit_counter64.sv
// csr_counter64: 64-bit counter whose halves can be overwritten; a write to
// either half replaces that cycle's increment and no carry is applied.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] value
);

   logic [63:0] value_q, value_d;

   // Half-write has priority over the increment; wrap at 2^64 is silent
   always_comb begin
      value_d = value_q;
      if (wr_lo) begin
         value_d[31:0] = wdata;
      end else if (wr_hi) begin
         value_d[63:32] = wdata;
      end else if (inc) begin
         value_d = value_q + 64'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with atomic read-modify-write, trap entry and
// MRET redirect. Define ZICNTR_EN to add mcycle/minstret and their read-only mirrors.
module csr_unit
   import csr_unit_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter logic [31:0] HART_ID     = 32'h0000_0000,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  csr_req_t        csr_req,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [4:0]      zimm,
   output logic [XLEN-1:0] csr_rdata,
   output logic            illegal_csr,
   input  logic            instr_retire,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret,
   input  logic            irq_sw,
   input  logic            irq_timer,
   input  logic            irq_ext,
   output logic            irq_pending,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   logic            mstatus_mie_q, mstatus_mie_d;
   logic            mstatus_mpie_q, mstatus_mpie_d;
   logic [2:0]      mie_q, mie_d;           // {MEIE, MTIE, MSIE}
   logic [2:0]      mip_q, mip_d;           // {MEIP, MTIP, MSIP}
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d;
   logic            irq_pending_q, irq_pending_d;
   logic            rst_done_q, rst_done_d;

   logic [XLEN-1:0] csr_opnd, csr_old, csr_wval;
   logic            csr_known, csr_ro, csr_wr_attempt, csr_we;
   logic            trap_take, mret_take;
   logic [2:0]      irq_vec;

`ifdef ZICNTR_EN
   logic [1:0][63:0] cnt_val;              // [0] mcycle, [1] minstret
   logic [1:0]       cnt_inc, cnt_wr_lo, cnt_wr_hi;
`else
   logic unused_instr_retire;
   assign unused_instr_retire = instr_retire;
`endif

   assign irq_vec = {irq_ext, irq_timer, irq_sw};

   // Decode the request: operand, old value, legality and the value to write back
   always_comb begin
      csr_opnd       = csr_req.use_imm ? {27'b0, zimm} : rs1_data;
      csr_wr_attempt = (csr_req.csr_mode == CSR_RW) ||
                       (((csr_req.csr_mode == CSR_RS) || (csr_req.csr_mode == CSR_RC)) && (zimm != 5'd0));
      csr_known      = 1'b1;
      csr_ro         = 1'b0;
      csr_old        = '0;
      case (csr_req.csr_target)
         CSR_ADDR_MSTATUS:  csr_old = mstatus_pack(mstatus_mie_q, mstatus_mpie_q);
         CSR_ADDR_MIE:      csr_old = mix_expand(mie_q);
         CSR_ADDR_MIP:      csr_old = mix_expand(mip_q);
         CSR_ADDR_MTVEC:    csr_old = mtvec_q;
         CSR_ADDR_MSCRATCH: csr_old = mscratch_q;
         CSR_ADDR_MEPC:     csr_old = mepc_q;
         CSR_ADDR_MCAUSE:   csr_old = mcause_q;
         CSR_ADDR_MTVAL:    csr_old = mtval_q;
         CSR_ADDR_MHARTID:  begin csr_old = HART_ID;             csr_ro = 1'b1; end
`ifdef ZICNTR_EN
         CSR_ADDR_MCYCLE:    csr_old = cnt_val[0][31:0];
         CSR_ADDR_MCYCLEH:   csr_old = cnt_val[0][63:32];
         CSR_ADDR_MINSTRET:  csr_old = cnt_val[1][31:0];
         CSR_ADDR_MINSTRETH: csr_old = cnt_val[1][63:32];
         CSR_ADDR_CYCLE:     begin csr_old = cnt_val[0][31:0];  csr_ro = 1'b1; end
         CSR_ADDR_CYCLEH:    begin csr_old = cnt_val[0][63:32]; csr_ro = 1'b1; end
         CSR_ADDR_INSTRET:   begin csr_old = cnt_val[1][31:0];  csr_ro = 1'b1; end
         CSR_ADDR_INSTRETH:  begin csr_old = cnt_val[1][63:32]; csr_ro = 1'b1; end
`endif
         default:           csr_known = 1'b0;
      endcase
      illegal_csr = csr_req.valid && (!csr_known || (csr_ro && csr_wr_attempt));
      csr_rdata   = (csr_req.valid && !illegal_csr) ? csr_old : '0;
      case (csr_req.csr_mode)
         CSR_RW:  csr_wval = csr_opnd;
         CSR_RS:  csr_wval = csr_old | csr_opnd;
         CSR_RC:  csr_wval = csr_old & ~csr_opnd;
         default: csr_wval = csr_old;
      endcase
   end

   // Trap beats MRET beats CSR write; nothing is taken in the first cycle out of reset
   assign trap_take      = trap_valid && rst_done_q;
   assign mret_take      = mret && rst_done_q && !trap_valid;
   assign csr_we         = csr_req.valid && !illegal_csr && csr_wr_attempt && !trap_take && !mret_take;
   assign redirect_valid = (trap_valid || mret) && rst_done_q;
   assign redirect_pc    = trap_valid ? trap_vector(mtvec_q, trap_cause) : mepc_q;
   assign irq_pending    = irq_pending_q;

   // Next-state for the architectural registers
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      if (trap_take) begin
         mepc_d         = {trap_pc[XLEN-1:2], 2'b00};
         mcause_d       = trap_cause;
         mtval_d        = trap_tval;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_take) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (csr_we) begin
         case (csr_req.csr_target)
            CSR_ADDR_MSTATUS: begin
               mstatus_mie_d  = csr_wval[MSTATUS_MIE];
               mstatus_mpie_d = csr_wval[MSTATUS_MPIE];
            end
            CSR_ADDR_MIE:      mie_d      = {csr_wval[MIX_MEI], csr_wval[MIX_MTI], csr_wval[MIX_MSI]};
            CSR_ADDR_MTVEC:    mtvec_d    = {csr_wval[XLEN-1:2], 1'b0, csr_wval[0]};
            CSR_ADDR_MSCRATCH: mscratch_d = csr_wval;
            CSR_ADDR_MEPC:     mepc_d     = {csr_wval[XLEN-1:2], 2'b00};
            CSR_ADDR_MCAUSE:   mcause_d   = csr_wval;
            CSR_ADDR_MTVAL:    mtval_d    = csr_wval;
            default:           ;
         endcase
      end
      mip_d         = irq_vec;
      irq_pending_d = mstatus_mie_q && ((mie_q & irq_vec) != 3'b000);
      rst_done_d    = 1'b1;
   end

   // Architectural state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mip_q          <= '0;
         mtvec_q        <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         irq_pending_q  <= 1'b0;
         rst_done_q     <= 1'b0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mip_q          <= mip_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         irq_pending_q  <= irq_pending_d;
         rst_done_q     <= rst_done_d;
      end
   end

`ifdef ZICNTR_EN
   // Counter controls: mcycle always counts, minstret counts retirements
   always_comb begin
      cnt_inc   = {instr_retire, 1'b1};
      cnt_wr_lo = {csr_we && (csr_req.csr_target == CSR_ADDR_MINSTRET),
                   csr_we && (csr_req.csr_target == CSR_ADDR_MCYCLE)};
      cnt_wr_hi = {csr_we && (csr_req.csr_target == CSR_ADDR_MINSTRETH),
                   csr_we && (csr_req.csr_target == CSR_ADDR_MCYCLEH)};
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      csr_counter64 u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (cnt_inc[gi]),
         .wr_lo (cnt_wr_lo[gi]),
         .wr_hi (cnt_wr_hi[gi]),
         .wdata (csr_wval),
         .value (cnt_val[gi])
      );
   end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed scenarios plus randomized traffic for csr_unit, checked
// every cycle against a behavioural model of the machine-mode CSR rules.
module tb_csr_unit;
   import csr_unit_pkg::*;

   localparam logic [31:0] HART      = 32'h0000_0005;
   localparam logic [31:0] MTVEC_RST = 32'h0000_0200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   csr_req_t    req;
   logic [31:0] rs1_data, trap_cause, trap_pc, trap_tval;
   logic [4:0]  zimm;
   logic        instr_retire, trap_valid, mret, irq_sw, irq_timer, irq_ext;
   logic [31:0] csr_rdata, redirect_pc;
   logic        illegal_csr, irq_pending, redirect_valid;

   always #5 clk = ~clk;

   csr_unit #(.XLEN(32), .HART_ID(HART), .MTVEC_RESET(MTVEC_RST)) dut (
      .clk(clk), .rst_n(rst_n), .csr_req(req), .rs1_data(rs1_data), .zimm(zimm),
      .csr_rdata(csr_rdata), .illegal_csr(illegal_csr), .instr_retire(instr_retire),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
      .mret(mret), .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
      .irq_pending(irq_pending), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic        m_mie, m_mpie, m_irq_pend;
   logic [31:0] m_mie_reg, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_cycle, m_instret;
   bit          m_alive;

   // Values seen in the most recent step
   logic [31:0] obs_rdata, obs_rpc;
   logic        obs_illegal, obs_rv;

   function automatic bit m_known(input logic [11:0] a);
      if (a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hF14})
         return 1'b1;
`ifdef ZICNTR_EN
      if (a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82})
         return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic bit m_readonly(input logic [11:0] a);
      return (a == 12'hF14) || (a[11:8] == 4'hC);
   endfunction

   function automatic logic [31:0] m_irq_bits();
      return (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_sw ? 32'h8 : 32'h0);
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
         12'h304: return m_mie_reg;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return m_mip;
         12'hF14: return HART;
         12'hB00, 12'hC00: return m_cycle[31:0];
         12'hB80, 12'hC80: return m_cycle[63:32];
         12'hB02, 12'hC02: return m_instret[31:0];
         12'hB82, 12'hC82: return m_instret[63:32];
         default: return 32'h0;
      endcase
   endfunction

   task automatic set_idle();
      req = '0; rs1_data = 32'h0; zimm = 5'd0; trap_valid = 1'b0; mret = 1'b0;
      instr_retire = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
   endtask

   task automatic set_csr(input csr_mode_t m, input logic [11:0] a, input bit imm,
                          input logic [31:0] r, input logic [4:0] z);
      req.valid = 1'b1; req.use_imm = imm; req.csr_mode = m; req.csr_target = a;
      rs1_data = r; zimm = z;
   endtask

   // One clock cycle: compare outputs to the model at the falling edge, then advance the model
   task automatic step();
      logic [11:0] a;
      logic [31:0] opnd, old, wv, vec;
      bit          wr, ill, trap_t, mret_t, do_wr, exp_rv;
      @(negedge clk);
      a    = req.csr_target;
      opnd = req.use_imm ? {27'b0, zimm} : rs1_data;
      wr   = (req.csr_mode == CSR_RW) || ((req.csr_mode == CSR_RS || req.csr_mode == CSR_RC) && zimm != 5'd0);
      ill  = req.valid && (!m_known(a) || (m_readonly(a) && wr));
      old  = (req.valid && !ill) ? m_read(a) : 32'h0;
      trap_t = trap_valid && m_alive;
      mret_t = mret && m_alive && !trap_valid;
      exp_rv = trap_t || mret_t;
      checks++;
      if (illegal_csr !== ill) begin
         errors++; $display("FAIL illegal_csr addr=%h: got %b expected %b", a, illegal_csr, ill);
      end
      checks++;
      if (csr_rdata !== old) begin
         errors++; $display("FAIL csr_rdata addr=%h: got %h expected %h", a, csr_rdata, old);
      end
      checks++;
      if (redirect_valid !== exp_rv) begin
         errors++; $display("FAIL redirect_valid: got %b expected %b", redirect_valid, exp_rv);
      end
      if (exp_rv) begin
         vec = trap_t ? ((m_mtvec & 32'hFFFF_FFFC) +
                         ((m_mtvec[0] && trap_cause[31]) ? (32'(trap_cause[4:0]) << 2) : 32'h0))
                      : m_mepc;
         checks++;
         if (redirect_pc !== vec) begin
            errors++; $display("FAIL redirect_pc: got %h expected %h", redirect_pc, vec);
         end
      end
      checks++;
      if (irq_pending !== m_irq_pend) begin
         errors++; $display("FAIL irq_pending: got %b expected %b", irq_pending, m_irq_pend);
      end
      obs_rdata = csr_rdata; obs_illegal = illegal_csr; obs_rv = redirect_valid; obs_rpc = redirect_pc;
      case (req.csr_mode)
         CSR_RW:  wv = opnd;
         CSR_RS:  wv = old | opnd;
         CSR_RC:  wv = old & ~opnd;
         default: wv = old;
      endcase
      do_wr = !trap_t && !mret_t && req.valid && !ill && wr;
      @(posedge clk);
      m_irq_pend = m_mie && ((m_mie_reg & m_irq_bits()) != 32'h0);
      m_mip      = m_irq_bits();
      if (trap_t) begin
         m_mepc = trap_pc & 32'hFFFF_FFFC; m_mcause = trap_cause; m_mtval = trap_tval;
         m_mpie = m_mie; m_mie = 1'b0;
      end else if (mret_t) begin
         m_mie = m_mpie; m_mpie = 1'b1;
      end else if (do_wr) begin
         case (a)
            12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
            12'h304: m_mie_reg  = wv & 32'h0000_0888;
            12'h305: m_mtvec    = wv & 32'hFFFF_FFFD;
            12'h340: m_mscratch = wv;
            12'h341: m_mepc     = wv & 32'hFFFF_FFFC;
            12'h342: m_mcause   = wv;
            12'h343: m_mtval    = wv;
            default: ;
         endcase
      end
      if (do_wr && a == 12'hB00)      m_cycle[31:0]  = wv;
      else if (do_wr && a == 12'hB80) m_cycle[63:32] = wv;
      else                            m_cycle        = m_cycle + 64'd1;
      if (do_wr && a == 12'hB02)      m_instret[31:0]  = wv;
      else if (do_wr && a == 12'hB82) m_instret[63:32] = wv;
      else if (instr_retire)          m_instret        = m_instret + 64'd1;
      m_alive = 1'b1;
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
      rst_n = 1'b0;
      m_mie = 1'b0; m_mpie = 1'b0; m_irq_pend = 1'b0; m_mie_reg = 32'h0; m_mip = 32'h0;
      m_mtvec = MTVEC_RST; m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
      m_cycle = 64'h0; m_instret = 64'h0; m_alive = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      // First cycle after release: a trap request must not redirect
      set_csr(CSR_RS, 12'h300, 1'b0, 32'h0, 5'd0);
      trap_valid = 1'b1; trap_cause = 32'h0000_0002; trap_pc = 32'h0000_0040;
      step();
      checks++;
      if (obs_rdata !== 32'h0000_1800) begin
         errors++; $display("FAIL reset_mstatus: got %h expected %h", obs_rdata, 32'h0000_1800);
      end
      checks++;
      if (obs_rv !== 1'b0) begin
         errors++; $display("FAIL reset_no_redirect: got %b expected 0", obs_rv);
      end
      set_idle();
      set_csr(CSR_RS, 12'h305, 1'b0, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_rdata !== MTVEC_RST) begin
         errors++; $display("FAIL reset_mtvec: got %h expected %h", obs_rdata, MTVEC_RST);
      end
      set_csr(CSR_RS, 12'h341, 1'b0, 32'h0, 5'd0);
      step();
   endtask

   task automatic test_scratch();
      set_idle();
      set_csr(CSR_RW, 12'h340, 1'b0, 32'hDEAD_BEEF, 5'd3);
      step();
      set_csr(CSR_RS, 12'h340, 1'b0, 32'hFFFF_FFFF, 5'd0);
      step();
      checks++;
      if (obs_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL scratch_read1: got %h expected DEADBEEF", obs_rdata);
      end
      set_csr(CSR_RS, 12'h340, 1'b1, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL scratch_nowrite: got %h expected DEADBEEF", obs_rdata);
      end
   endtask

   task automatic test_mstatus_clear();
      set_idle();
      set_csr(CSR_RS, 12'h300, 1'b1, 32'h0, 5'd8);
      step();
      set_csr(CSR_RC, 12'h300, 1'b1, 32'h0, 5'd8);
      step();
      checks++;
      if (obs_rdata[3] !== 1'b1) begin
         errors++; $display("FAIL rc_old_mie: got %b expected 1", obs_rdata[3]);
      end
      set_csr(CSR_RS, 12'h300, 1'b1, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_rdata[3] !== 1'b0) begin
         errors++; $display("FAIL rc_new_mie: got %b expected 0", obs_rdata[3]);
      end
   endtask

   task automatic test_trap_vectored();
      set_idle();
      set_csr(CSR_RW, 12'h305, 1'b0, 32'h0000_0101, 5'd1);
      step();
      set_csr(CSR_RS, 12'h304, 1'b0, 32'h0000_0800, 5'd1);
      irq_ext = 1'b1;
      step();
      set_csr(CSR_RS, 12'h300, 1'b1, 32'h0, 5'd8);
      step();
      checks++;
      if (irq_pending !== 1'b0) begin
         errors++; $display("FAIL irq_pending_early: got %b expected 0", irq_pending);
      end
      set_idle();
      step();
      checks++;
      if (irq_pending !== 1'b1) begin
         errors++; $display("FAIL irq_pending_late: got %b expected 1", irq_pending);
      end
      // Trap with a concurrent write that must be dropped
      set_csr(CSR_RW, 12'h340, 1'b0, 32'h0000_0055, 5'd2);
      trap_valid = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h0000_4000; trap_tval = 32'h0000_1234;
      step();
      checks++;
      if (obs_rpc !== 32'h0000_012C) begin
         errors++; $display("FAIL trap_vector: got %h expected 0000012C", obs_rpc);
      end
      checks++;
      if (obs_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL trap_discard_rdata: got %h expected DEADBEEF", obs_rdata);
      end
      set_idle();
      set_csr(CSR_RS, 12'h300, 1'b0, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_rdata !== 32'h0000_1880) begin
         errors++; $display("FAIL trap_mstatus: got %h expected 00001880", obs_rdata);
      end
   endtask

   task automatic test_mret_priority();
      set_idle();
      set_csr(CSR_RW, 12'h341, 1'b0, 32'h0000_8888, 5'd4);
      mret = 1'b1;
      step();
      checks++;
      if (obs_rpc !== 32'h0000_4000) begin
         errors++; $display("FAIL mret_pc: got %h expected 00004000", obs_rpc);
      end
      set_idle();
      set_csr(CSR_RS, 12'h341, 1'b0, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_rdata !== 32'h0000_4000) begin
         errors++; $display("FAIL mret_write_dropped: got %h expected 00004000", obs_rdata);
      end
      set_csr(CSR_RS, 12'h300, 1'b0, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_rdata !== 32'h0000_1888) begin
         errors++; $display("FAIL mret_mstatus: got %h expected 00001888", obs_rdata);
      end
   endtask

   task automatic test_illegal();
      set_idle();
      set_csr(CSR_RW, 12'hF14, 1'b0, 32'h1111_1111, 5'd1);
      step();
      checks++;
      if (obs_illegal !== 1'b1 || obs_rdata !== 32'h0) begin
         errors++; $display("FAIL hartid_write: got ill=%b rdata=%h expected ill=1 rdata=0", obs_illegal, obs_rdata);
      end
      set_csr(CSR_RS, 12'hF14, 1'b0, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_rdata !== HART) begin
         errors++; $display("FAIL hartid_read: got %h expected %h", obs_rdata, HART);
      end
      set_csr(CSR_RW, 12'h7C0, 1'b0, 32'h2222_2222, 5'd1);
      step();
      checks++;
      if (obs_illegal !== 1'b1) begin
         errors++; $display("FAIL addr_7c0: got %b expected 1", obs_illegal);
      end
      set_csr(CSR_RS, 12'h340, 1'b0, 32'h0, 5'd0);
      step();
   endtask

   task automatic test_counters();
      set_idle();
`ifdef ZICNTR_EN
      set_csr(CSR_RW, 12'hB00, 1'b0, 32'hFFFF_FFFF, 5'd1);
      step();
      set_idle();
      step();
      set_csr(CSR_RS, 12'hB00, 1'b0, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_rdata !== 32'h0) begin
         errors++; $display("FAIL mcycle_wrap_lo: got %h expected 0", obs_rdata);
      end
      set_csr(CSR_RS, 12'hC80, 1'b0, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_rdata !== 32'h1) begin
         errors++; $display("FAIL mcycle_wrap_hi: got %h expected 1", obs_rdata);
      end
      set_csr(CSR_RW, 12'hB82, 1'b0, 32'h0000_0007, 5'd1);
      instr_retire = 1'b1;
      step();
      set_csr(CSR_RW, 12'hC00, 1'b0, 32'h0, 5'd1);
      step();
      checks++;
      if (obs_illegal !== 1'b1) begin
         errors++; $display("FAIL cycle_mirror_write: got %b expected 1", obs_illegal);
      end
`else
      set_csr(CSR_RS, 12'hB00, 1'b0, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_illegal !== 1'b1) begin
         errors++; $display("FAIL mcycle_disabled: got %b expected 1", obs_illegal);
      end
      set_csr(CSR_RS, 12'hC02, 1'b0, 32'h0, 5'd0);
      step();
      checks++;
      if (obs_illegal !== 1'b1) begin
         errors++; $display("FAIL instret_disabled: got %b expected 1", obs_illegal);
      end
`endif
   endtask

   task automatic test_random();
      logic [11:0] addrs [17] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                  12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                                  12'hC82, 12'h7C0, 12'h123};
      for (int i = 0; i < 400; i++) begin
         set_idle();
         req.valid      = ($urandom_range(0, 9) != 0);
         req.use_imm    = $urandom_range(0, 1) == 1;
         req.csr_mode   = csr_mode_t'($urandom_range(0, 3));
         req.csr_target = addrs[$urandom_range(0, 16)];
         rs1_data       = $urandom;
         zimm           = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         instr_retire   = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 15) == 0) begin
            trap_valid = 1'b1;
            trap_cause = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | 32'($urandom_range(0, 15)))
                                                     : 32'($urandom_range(0, 15));
            trap_pc    = $urandom & 32'hFFFF_FFFC;
            trap_tval  = $urandom;
         end
         mret = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0) irq_ext   = ~irq_ext;
         if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
         if ($urandom_range(0, 7) == 0) irq_sw    = ~irq_sw;
         step();
      end
   endtask

   task automatic test_async_reset();
      set_idle();
      set_csr(CSR_RW, 12'h340, 1'b0, 32'h0BAD_F00D, 5'd1);
      step();
      set_csr(CSR_RS, 12'h340, 1'b0, 32'h0, 5'd0);
      trap_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (csr_rdata !== 32'h0) begin
         errors++; $display("FAIL async_reset_scratch: got %h expected 0", csr_rdata);
      end
      checks++;
      if (redirect_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset_redirect: got %b expected 0", redirect_valid);
      end
      do_reset();
      set_csr(CSR_RS, 12'h340, 1'b0, 32'h0, 5'd0);
      step();
   endtask

   initial begin
      set_idle();
      irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
      test_reset();
      test_scratch();
      test_mstatus_clear();
      test_trap_vectored();
      test_mret_priority();
      test_illegal();
      test_counters();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
